// File: rtl/id_stage_pipelined_pkg.sv
// Shared constants and encodings for the registered decode (ID) stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds the default widths used by id_stage_pipelined and id_reg_file_bypass,
// the ALU-type encodings produced by id_decoder, and the hardwired-zero
// register index.
package id_stage_pipelined_pkg;

    // Default widths; modules take these as parameter defaults.
    localparam int XLEN_DEF  = 32;
    localparam int NREG_DEF  = 32;
    localparam int REG_W_DEF = 5;
    localparam int ALU_W_DEF = 4;

    // Register index that always reads as zero and ignores writes.
    localparam int ZERO_REG = 0;

    // ALU operation encodings carried from the decoder through ID/EX.
    typedef enum logic [ALU_W_DEF-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLL  = 4'h2,
        ALU_SLT  = 4'h3,
        ALU_SLTU = 4'h4,
        ALU_XOR  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_OR   = 4'h8,
        ALU_AND  = 4'h9,
        ALU_LUI  = 4'hA,
        ALU_PASS = 4'hB
    } alu_type_e;

    // True when a source index names a real (non-zero) register.
    function automatic logic is_live_reg(input logic [REG_W_DEF-1:0] idx);
        return idx != REG_W_DEF'(ZERO_REG);
    endfunction

endpackage

// File: rtl/id_reg_file_bypass.sv
// Architectural register file with EX/MEM and WB bypass on both read ports.
// Latency: reads are combinational; the write lands at the rising clock edge.
// Backpressure: none; the write port is always accepted.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset (clears all regs)
//   wb_we/wb_rd/wb_data write port; writes to register 0 are dropped
//   fwd_valid/fwd_rd/fwd_data  EX/MEM non-load result for bypass
//   rs1, rs2            read indices
//   src1, src2          resolved operands
module id_reg_file_bypass
    import id_stage_pipelined_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int REG_W = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_we,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             fwd_valid,
    input  logic [REG_W-1:0] fwd_rd,
    input  logic [XLEN-1:0]  fwd_data,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic [XLEN-1:0]  src1,
    output logic [XLEN-1:0]  src2
);

    if ($clog2(NREG) != REG_W) begin : g_bad_reg_w
        $error("REG_W must equal clog2(NREG)");
    end

    logic [XLEN-1:0] regs [NREG];

    // Register 0 is never written, so after reset it stays zero in storage
    // as well as being forced to zero on the read side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we && (wb_rd != REG_W'(ZERO_REG)) && (int'(wb_rd) < NREG)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Read priority: zero register, then the younger EX/MEM result, then the
    // WB value being written this cycle, then storage. Indices beyond NREG
    // (possible when NREG is not a power of two) read as zero.
    function automatic logic [XLEN-1:0] resolve(input logic [REG_W-1:0] rs,
                                                input logic [XLEN-1:0] stored);
        logic [XLEN-1:0] val;
        val = stored;
        if (rs == REG_W'(ZERO_REG)) begin
            val = '0;
        end else if (fwd_valid && (fwd_rd == rs)) begin
            val = fwd_data;
        end else if (wb_we && (wb_rd == rs)) begin
            val = wb_data;
        end
        return val;
    endfunction

    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;

    always_comb begin
        rf_rd1 = '0;
        rf_rd2 = '0;
        if (int'(rs1) < NREG) begin
            rf_rd1 = regs[rs1];
        end
        if (int'(rs2) < NREG) begin
            rf_rd2 = regs[rs2];
        end
    end

    assign src1 = resolve(rs1, rf_rd1);
    assign src2 = resolve(rs2, rf_rd2);

endmodule

// File: rtl/id_stage_pipelined.sv
// Registered decode stage: operand read with bypass, load-use stall, ID/EX register.
// Latency: 1 cycle from accept (in_valid & in_ready) to out_valid.
// Backpressure: out_ready low holds ID/EX and drops in_ready; hazards and flush also drop in_ready.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready + in_*     decoded instruction from IF/ID / id_decoder
//   fwd_valid/fwd_rd/fwd_data    EX/MEM non-load result for bypass
//   mem_load_valid/mem_load_rd   load in MEM whose data is not yet available
//   wb_we/wb_rd/wb_data          register-file write-back port
//   flush                        kills ID/EX contents and this cycle's input
//   out_valid/out_ready + out_*  ID/EX register towards EX
module id_stage_pipelined
    import id_stage_pipelined_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int REG_W = REG_W_DEF,
    parameter int ALU_W = ALU_W_DEF
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ALU_W-1:0] in_alu_type,
    input  logic [REG_W-1:0] in_rd,
    input  logic             in_rd_wen,
    input  logic [REG_W-1:0] in_rs1,
    input  logic [REG_W-1:0] in_rs2,
    input  logic             in_use_rs1,
    input  logic             in_use_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_imm_tag,
    input  logic             in_is_load,

    input  logic             fwd_valid,
    input  logic [REG_W-1:0] fwd_rd,
    input  logic [XLEN-1:0]  fwd_data,

    input  logic             mem_load_valid,
    input  logic [REG_W-1:0] mem_load_rd,

    input  logic             wb_we,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,

    input  logic             flush,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [ALU_W-1:0] out_alu_type,
    output logic [REG_W-1:0] out_rd,
    output logic             out_rd_wen,
    output logic             out_is_load,
    output logic [XLEN-1:0]  out_src1,
    output logic [XLEN-1:0]  out_src2,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_imm_tag
);

    logic [XLEN-1:0] rd_src1;
    logic [XLEN-1:0] rd_src2;
    logic            hazard;
    logic            capture;

    id_reg_file_bypass #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .REG_W (REG_W)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .src1      (rd_src1),
        .src2      (rd_src2)
    );

    // A source waits on a load that has not produced data yet: either the
    // load is still in ID/EX, or it is in MEM. Once the load reaches WB its
    // value arrives through the WB bypass, so no third check is needed.
    function automatic logic src_blocked(input logic use_rs, input logic [REG_W-1:0] rs);
        logic in_idex;
        logic in_mem;
        in_idex = out_valid && out_is_load && out_rd_wen && (out_rd == rs);
        in_mem  = mem_load_valid && (mem_load_rd == rs);
        return use_rs && (rs != REG_W'(ZERO_REG)) && (in_idex || in_mem);
    endfunction

    always_comb begin
        hazard = 1'b0;
        if (in_valid) begin
            hazard = src_blocked(in_use_rs1, in_rs1) || src_blocked(in_use_rs2, in_rs2);
        end
    end

    assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush & ~rst;
    assign capture  = in_valid & in_ready;

    // Valid bit: flush beats everything; a consumed entry with no new capture
    // leaves a bubble; otherwise the entry holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload only moves on capture so EX sees stable operands while stalled
    // and the datapath does not toggle through bubbles. capture already
    // excludes flush via in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_alu_type <= '0;
            out_rd       <= '0;
            out_rd_wen   <= 1'b0;
            out_is_load  <= 1'b0;
            out_src1     <= '0;
            out_src2     <= '0;
            out_imm      <= '0;
            out_imm_tag  <= 1'b0;
        end else if (capture) begin
            out_alu_type <= in_alu_type;
            out_rd       <= in_rd;
            out_rd_wen   <= in_rd_wen;
            out_is_load  <= in_is_load;
            out_src1     <= rd_src1;
            out_src2     <= rd_src2;
            out_imm      <= in_imm;
            out_imm_tag  <= in_imm_tag;
        end
    end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Scoreboard bench for id_stage_pipelined: directed instructions with hand-computed operands.
// Latency: expects each accepted instruction on out_* one cycle after acceptance.
// Backpressure: drives out_ready low in chosen windows and expects in_ready/outputs to hold.
module tb_id_stage_pipelined;

    typedef struct packed {
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        is_load;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] imm;
        logic        imm_tag;
    } exp_t;

    typedef struct packed {
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use1;
        logic        use2;
        logic [31:0] imm;
        logic        imm_tag;
        logic        is_load;
    } ins_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_alu_type = '0;
    logic [4:0]  in_rd = '0;
    logic        in_rd_wen = 1'b0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic        in_use_rs1 = 1'b0;
    logic        in_use_rs2 = 1'b0;
    logic [31:0] in_imm = '0;
    logic        in_imm_tag = 1'b0;
    logic        in_is_load = 1'b0;
    logic        fwd_valid = 1'b0;
    logic [4:0]  fwd_rd = '0;
    logic [31:0] fwd_data = '0;
    logic        mem_load_valid = 1'b0;
    logic [4:0]  mem_load_rd = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_alu_type;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    logic        out_is_load;
    logic [31:0] out_src1;
    logic [31:0] out_src2;
    logic [31:0] out_imm;
    logic        out_imm_tag;

    int n_vec = 0;
    int n_err = 0;
    exp_t exp_q[$];
    exp_t act;

    assign act = {out_alu_type, out_rd, out_rd_wen, out_is_load,
                  out_src1, out_src2, out_imm, out_imm_tag};

    always #5 clk = ~clk;

    id_stage_pipelined dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_alu_type    (in_alu_type),
        .in_rd          (in_rd),
        .in_rd_wen      (in_rd_wen),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_use_rs1     (in_use_rs1),
        .in_use_rs2     (in_use_rs2),
        .in_imm         (in_imm),
        .in_imm_tag     (in_imm_tag),
        .in_is_load     (in_is_load),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data),
        .mem_load_valid (mem_load_valid),
        .mem_load_rd    (mem_load_rd),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alu_type   (out_alu_type),
        .out_rd         (out_rd),
        .out_rd_wen     (out_rd_wen),
        .out_is_load    (out_is_load),
        .out_src1       (out_src1),
        .out_src2       (out_src2),
        .out_imm        (out_imm),
        .out_imm_tag    (out_imm_tag)
    );

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Monitor: every instruction EX consumes must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 128'(act), 128'(0));
            end else begin
                chk("idex_payload", 128'(act), 128'(exp_q.pop_front()));
            end
        end
    end

    function automatic ins_t mk(input logic [3:0] alu, input logic [4:0] rd,
                                input logic rd_wen, input logic [4:0] rs1,
                                input logic use1, input logic [4:0] rs2,
                                input logic use2, input logic [31:0] imm,
                                input logic imm_tag, input logic is_load);
        ins_t i;
        i = '{alu, rd, rd_wen, rs1, rs2, use1, use2, imm, imm_tag, is_load};
        return i;
    endfunction

    task automatic clear_side();
        in_valid       = 1'b0;
        wb_we          = 1'b0;
        fwd_valid      = 1'b0;
        mem_load_valid = 1'b0;
        flush          = 1'b0;
    endtask

    // One cycle with an instruction offered. Side-band inputs are set by the
    // caller beforehand and cleared here after the edge.
    task automatic issue(input ins_t i, input bit exp_acc,
                         input logic [31:0] s1, input logic [31:0] s2);
        exp_t e;
        in_valid    = 1'b1;
        in_alu_type = i.alu;
        in_rd       = i.rd;
        in_rd_wen   = i.rd_wen;
        in_rs1      = i.rs1;
        in_rs2      = i.rs2;
        in_use_rs1  = i.use1;
        in_use_rs2  = i.use2;
        in_imm      = i.imm;
        in_imm_tag  = i.imm_tag;
        in_is_load  = i.is_load;
        @(negedge clk);
        chk("in_ready", 128'(in_ready), 128'(exp_acc));
        if (exp_acc) begin
            e = '{i.alu, i.rd, i.rd_wen, i.is_load, s1, s2, i.imm, i.imm_tag};
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        clear_side();
    endtask

    task automatic wb_only(input logic [4:0] rd, input logic [31:0] d);
        wb_we = 1'b1;
        wb_rd = rd;
        wb_data = d;
        @(posedge clk);
        #1;
        clear_side();
    endtask

    ins_t ia, ib;
    exp_t ea;

    initial begin
        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_regs", 128'(act), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Preload registers through write-back
        wb_only(5'd1, 32'h0000_0100);
        wb_only(5'd2, 32'h0000_0200);
        wb_only(5'd5, 32'h0000_0055);
        wb_only(5'd0, 32'hFFFF_FFFF);

        // Plain reads, back-to-back, plus x0 reads zero despite the write above
        issue(mk(4'h0, 5'd6, 1, 5'd1, 1, 5'd2, 1, 32'h7, 0, 0), 1, 32'h100, 32'h200);
        issue(mk(4'h8, 5'd8, 1, 5'd2, 1, 5'd0, 0, 32'hFFFF_FFF0, 1, 0), 1, 32'h200, 32'h0);

        // WB write-through, then the stored value
        wb_we = 1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
        issue(mk(4'h1, 5'd9, 1, 5'd3, 1, 5'd0, 0, 32'h0, 0, 0), 1, 32'hDEAD_BEEF, 32'h0);
        issue(mk(4'h5, 5'd9, 1, 5'd3, 1, 5'd1, 1, 32'h0, 0, 0), 1, 32'hDEAD_BEEF, 32'h100);

        // Forward beats WB on the same register; rs=0 ignores a forward to x0
        fwd_valid = 1; fwd_rd = 5'd7; fwd_data = 32'h11;
        wb_we = 1; wb_rd = 5'd7; wb_data = 32'h22;
        issue(mk(4'h0, 5'd10, 1, 5'd1, 1, 5'd7, 1, 32'h0, 0, 0), 1, 32'h100, 32'h11);
        fwd_valid = 1; fwd_rd = 5'd0; fwd_data = 32'h11;
        issue(mk(4'h0, 5'd10, 1, 5'd7, 1, 5'd0, 1, 32'h0, 0, 0), 1, 32'h22, 32'h0);

        // Load-use stall on x4
        issue(mk(4'h0, 5'd4, 1, 5'd1, 1, 5'd0, 0, 32'h8, 1, 1), 1, 32'h100, 32'h0);
        ia = mk(4'h0, 5'd11, 1, 5'd4, 1, 5'd2, 1, 32'h0, 0, 0);
        issue(ia, 0, 32'h0, 32'h0);
        chk("loaduse_bubble", 128'(out_valid), 128'(0));
        mem_load_valid = 1; mem_load_rd = 5'd4;
        issue(ia, 0, 32'h0, 32'h0);
        wb_we = 1; wb_rd = 5'd4; wb_data = 32'h0000_CAFE;
        issue(ia, 1, 32'h0000_CAFE, 32'h200);

        // A load followed by an instruction that names rd but does not read it
        issue(mk(4'h0, 5'd12, 1, 5'd0, 0, 5'd0, 0, 32'h0, 1, 1), 1, 32'h0, 32'h0);
        issue(mk(4'h9, 5'd13, 1, 5'd12, 0, 5'd12, 0, 32'h3, 1, 0), 1, 32'h0, 32'h0);

        // Backpressure: A held for three cycles while B waits
        ia = mk(4'h2, 5'd14, 1, 5'd1, 1, 5'd5, 1, 32'h1, 0, 0);
        ea = '{4'h2, 5'd14, 1'b1, 1'b0, 32'h100, 32'h55, 32'h1, 1'b0};
        issue(ia, 1, 32'h100, 32'h55);
        out_ready = 1'b0;
        ib = mk(4'h3, 5'd15, 1, 5'd2, 1, 5'd1, 1, 32'h2, 0, 0);
        for (int k = 0; k < 3; k++) begin
            issue(ib, 0, 32'h0, 32'h0);
            chk("bp_hold_valid", 128'(out_valid), 128'(1));
            chk("bp_hold_regs", 128'(act), 128'(ea));
        end
        out_ready = 1'b1;
        issue(ib, 1, 32'h200, 32'h100);

        // Flush kills ID/EX and the offered input; the WB write still lands
        issue(mk(4'h0, 5'd16, 1, 5'd1, 1, 5'd0, 0, 32'h0, 0, 0), 1, 32'h100, 32'h0);
        out_ready = 1'b0;
        flush = 1; wb_we = 1; wb_rd = 5'd9; wb_data = 32'h5;
        issue(mk(4'h0, 5'd17, 1, 5'd2, 1, 5'd0, 0, 32'h0, 0, 0), 0, 32'h0, 32'h0);
        void'(exp_q.pop_back());
        chk("flush_valid", 128'(out_valid), 128'(0));
        out_ready = 1'b1;
        issue(mk(4'h0, 5'd18, 1, 5'd9, 1, 5'd0, 0, 32'h0, 0, 0), 1, 32'h5, 32'h0);

        // Reset while ID/EX is valid
        issue(mk(4'h0, 5'd19, 1, 5'd2, 1, 5'd0, 0, 32'h0, 0, 0), 1, 32'h200, 32'h0);
        void'(exp_q.pop_back());
        rst = 1'b1;
        #1;
        chk("midrst_valid", 128'(out_valid), 128'(0));
        chk("midrst_regs", 128'(act), 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        issue(mk(4'h0, 5'd20, 1, 5'd5, 1, 5'd3, 1, 32'h0, 0, 0), 1, 32'h0, 32'h0);

        // Drain
        repeat (3) begin
            @(posedge clk);
        end
        #1;
        chk("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
- Parametrised, registered successor to the combinational decode stage.
- Takes decoded fields from id_decoder and owns the architectural register file.
- Reads operands with EX/MEM and WB bypass, detects load-use hazards, and presents operands to EX through a valid/ready ID/EX pipeline register.
- Sits between the IF/ID register and the EX stage, with one cycle of latency.

Parameters:
- XLEN, 32, data and immediate width.
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.
- REG_W, 5, register index width; must equal clog2(NREG).
- ALU_W, 4, ALU-type encoding width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_alu_type  in  ALU_W  decoded ALU operation.
- in_rd  in  REG_W  destination register index.
- in_rd_wen  in  1  instruction writes rd.
- in_rs1, in_rs2  in  REG_W  source register indices.
- in_use_rs1, in_use_rs2  in  1  source register is actually read.
- in_imm  in  XLEN  extended immediate.
- in_imm_tag  in  1  immediate replaces src2 in EX.
- in_is_load  in  1  instruction is a load.
- fwd_valid  in  1  EX/MEM non-load result available.
- fwd_rd  in  REG_W  register written by that result.
- fwd_data  in  XLEN  value of that result.
- mem_load_valid  in  1  load in MEM stage, data not yet available.
- mem_load_rd  in  REG_W  destination register of that load.
- wb_we  in  1  write-back enable.
- wb_rd  in  REG_W  write-back register index.
- wb_data  in  XLEN  write-back value.
- flush  in  1  synchronous kill of ID/EX contents and any input this cycle.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX consumes the instruction.
- out_alu_type  out  ALU_W  registered ALU type.
- out_rd  out  REG_W  registered destination index.
- out_rd_wen  out  1  registered rd write enable.
- out_is_load  out  1  registered load flag.
- out_src1, out_src2  out  XLEN  registered resolved operands.
- out_imm  out  XLEN  registered immediate.
- out_imm_tag  out  1  registered immediate select.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0 and every out_* register=0.
  - All NREG registers cleared to 0.
  - in_ready=0 while rst is high.
- Register file:
  - Write at the clock edge when wb_we=1 and wb_rd!=0.
  - Writes to register 0 are ignored; register 0 always reads 0.
- Operand resolution (combinational, per source rsN):
  - If rsN==0, the result is 0.
  - Else if fwd_valid and fwd_rd==rsN, the result is fwd_data.
  - Else if wb_we and wb_rd==rsN, the result is wb_data (same-cycle write-through).
  - Else the result is the register file value.
- Hazard (combinational). hazard=1 when in_valid and, for some N with in_use_rsN=1 and in_rsN!=0, either:
  - out_valid, out_is_load, out_rd_wen and out_rd==in_rsN; or
  - mem_load_valid and mem_load_rd==in_rsN.
- Handshake:
  - in_ready = (~out_valid | out_ready) & ~hazard & ~flush & ~rst.
  - Capture when in_valid & in_ready: all out_* registers load the in_* fields and resolved operands; out_valid<=1 on the next edge.
  - When out_valid & out_ready and no capture: out_valid<=0 (bubble inserted).
  - When out_valid & ~out_ready: all out_* registers hold and in_ready=0.
  - out_* data registers are don't-care when out_valid=0, but must not toggle when nothing is captured.
- Flush:
  - Highest priority: out_valid<=0 on the next edge and no capture that cycle.
  - The register-file write proceeds normally.
- Latency: 1 cycle from accept to out_valid. Throughput is 1 instruction/cycle absent hazards and backpressure.
- Simultaneous cases:
  - WB and EX/MEM forward to the same register: fwd_data wins.
  - WB write to the register being read: the new value is used.
  - Hazard and out_ready both asserted: out_valid drops to 0 (the bubble); the stalled instruction is accepted once the hazard clears.

Decomposition:
- Shared package / define header: XLEN, NREG, REG_W, ALU_W defaults; ALU-type encodings; ZERO_REG index constant.
- One natural sub-module, id_reg_file_bypass:
  - Parametrised NREG x XLEN array with async reset.
  - Two combinational read ports with the forwarding priority above, one write port.
- Hazard detection, handshake and the ID/EX register live in the top module.

Test Plan:
- Reset mid-stream: assert rst with out_valid=1 -> out_valid=0 immediately; after release, reading x5 returns 0.
- WB bypass: wb_we=1, wb_rd=3, wb_data=0xDEAD_BEEF in the same cycle as in_rs1=3 accepted -> out_src1=0xDEAD_BEEF next cycle; register 3 holds it afterwards.
- Forward priority: fwd_rd=7, fwd_data=0x11; wb_rd=7, wb_data=0x22; in_rs2=7 -> out_src2=0x11. With in_rs2=0 and fwd_rd=0, fwd_data=0x11 -> out_src2=0.
- Load-use stall:
  - Stimulus: load to x4 sits in ID/EX; next instruction uses rs1=4.
  - Cycle 1: in_ready=0; with out_ready=1, out_valid=0.
  - Cycle 2: with mem_load_valid=1, mem_load_rd=4, still stalled.
  - Cycle 3: once the load leaves MEM, the instruction is accepted with the WB-forwarded value.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; the instruction is accepted in the cycle out_ready rises.
- Flush: flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0, input not captured, a same-cycle wb write to x9=0x5 still lands.
